// File: rtl/controller_oci_dct_pkg.sv
// controller_oci_dct_pkg: shared scheduler state encoding and default geometry.
package controller_oci_dct_pkg;
    typedef logic [0:0] state_t;
    localparam state_t FILL = 1'b0;
    localparam state_t HOLD = 1'b1;
    localparam int FRAG_W_DEF = 6;
    localparam int NFRAG_DEF  = 5;
endpackage

// File: rtl/controller_nios2_qsys_0_oci_dct_rr_arb.sv
// controller_nios2_qsys_0_oci_dct_rr_arb: two-way trace arbiter, round-robin by default.
// Define CONTROLLER_OCI_DCT_FIXED_PRIO_EN for fixed A-over-B priority without a pointer.
module controller_nios2_qsys_0_oci_dct_rr_arb (
    input  logic clk,
    input  logic reset_n,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic accept_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);
`ifdef CONTROLLER_OCI_DCT_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, reset_n, accept_i};
    assign gnt_a_o   = req_a_i;
`else
    // pref_b_q set means A won last, so B is preferred on a tie
    logic pref_b_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pref_b_q <= 1'b0;
        else if (accept_i) pref_b_q <= gnt_a_o;
    assign gnt_a_o = req_a_i && (!req_b_i || !pref_b_q);
`endif
    assign gnt_b_o = req_b_i && !gnt_a_o;
endmodule

// File: rtl/controller_nios2_qsys_0_oci_dct_sched.sv
// controller_nios2_qsys_0_oci_dct_sched: packs A/B trace fragments into a buffer and hands it off.
// Arbitration becomes fixed priority when CONTROLLER_OCI_DCT_FIXED_PRIO_EN is defined.
module controller_nios2_qsys_0_oci_dct_sched
    import controller_oci_dct_pkg::*;
#(
    parameter int FRAG_W = FRAG_W_DEF,
    parameter int NFRAG  = NFRAG_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid,
    input  logic [FRAG_W-1:0]       a_frag,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [FRAG_W-1:0]       b_frag,
    output logic                    b_ready,
    input  logic                    test_ending,
    output logic [FRAG_W*NFRAG-1:0] dct_buffer,
    output logic [3:0]              dct_count,
    output logic                    dct_valid,
    input  logic                    dct_ready,
    output logic                    test_has_ended
);
    localparam int BW = FRAG_W * NFRAG;
    state_t            state_q, state_d;
    logic [BW-1:0]     buf_q, buf_d;
    logic [3:0]        cnt_q, cnt_d, cnt_acc;
    logic              pend_q, pend_d, flush_q, flush_d, ended_q, ended_d;
    logic              fill, gnt_a, gnt_b, accept, flush_req;
    logic [FRAG_W-1:0] frag;
    assign fill = reset_n && state_q == FILL;
    controller_nios2_qsys_0_oci_dct_rr_arb u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_a_i  (a_valid && fill),
        .req_b_i  (b_valid && fill),
        .accept_i (accept),
        .gnt_a_o  (gnt_a),
        .gnt_b_o  (gnt_b)
    );
    assign accept    = gnt_a || gnt_b;
    assign frag      = gnt_a ? a_frag : b_frag;
    assign cnt_acc   = cnt_q + {3'b000, accept};
    assign flush_req = test_ending || pend_q;
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        flush_d = flush_q;
        ended_d = ended_q;
        if (state_q == FILL) begin
            for (int k = 0; k < NFRAG; k++)
                if (accept && cnt_q == 4'(k)) buf_d[k*FRAG_W +: FRAG_W] = frag;
            cnt_d  = cnt_acc;
            pend_d = 1'b0;
            if (cnt_acc == 4'(NFRAG) || (flush_req && cnt_acc != 4'd0)) begin
                state_d = HOLD;
                flush_d = flush_req;
            end else if (flush_req) ended_d = 1'b1;
        end else begin
            // a flush arriving while the consumer stalls waits for the next fill
            pend_d = pend_q || test_ending;
            if (dct_ready) begin
                state_d = FILL;
                buf_d   = '0;
                cnt_d   = '0;
                flush_d = 1'b0;
                ended_d = ended_q || flush_q;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            flush_q <= 1'b0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            ended_q <= ended_d;
        end
    assign a_ready        = gnt_a;
    assign b_ready        = gnt_b;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign dct_valid      = state_q == HOLD;
    assign test_has_ended = ended_q;
endmodule

// File: doc/controller_nios2_qsys_0_oci_dct_sched.md
CONTROLLER_NIOS2_QSYS_0_OCI_DCT_SCHED -- requirements
Module: controller_nios2_qsys_0_oci_dct_sched

Interface
REQ-001 Parameter FRAG_W, default 6, trace fragment width in bits.
REQ-002 Parameter NFRAG, default 5, fragments per buffer; buffer width is FRAG_W*NFRAG (30 by default).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  requester A (instruction trace) offers a fragment.
REQ-006 a_frag  input  FRAG_W  requester A fragment.
REQ-007 a_ready  output  1  requester A fragment accepted this cycle.
REQ-008 b_valid  input  1  requester B (data trace) offers a fragment.
REQ-009 b_frag  input  FRAG_W  requester B fragment.
REQ-010 b_ready  output  1  requester B fragment accepted this cycle.
REQ-011 test_ending  input  1  single-cycle request to flush a partial buffer.
REQ-012 dct_buffer  output  FRAG_W*NFRAG  packed fragments, fragment k in bits [FRAG_W*k+FRAG_W-1 : FRAG_W*k].
REQ-013 dct_count  output  4  number of valid fragments in dct_buffer, 0..NFRAG.
REQ-014 dct_valid  output  1  dct_buffer/dct_count held for consumer.
REQ-015 dct_ready  input  1  consumer takes buffer when dct_valid and dct_ready are both high.
REQ-016 test_has_ended  output  1  sticky; set when a flush has completed (buffer drained or flushed buffer empty).

Function
REQ-017 FSM states: FILL, HOLD; reset state FILL.
REQ-018 In FILL, at most one fragment is accepted per cycle; a_ready/b_ready are combinational from the grant, never both high, and are low in HOLD.
REQ-019 Arbitration: only one valid -> that requester wins; both valid -> round-robin, the requester not granted most recently wins; pointer updates only on an accepted fragment; initial preference after reset is A.
REQ-020 An accepted fragment is written at slot dct_count and dct_count increments by 1 in the same edge.
REQ-021 FILL -> HOLD when the accepted fragment brings dct_count to NFRAG.
REQ-022 FILL -> HOLD on test_ending when dct_count (after any same-cycle accept) is nonzero; the same-cycle fragment is included.
REQ-023 test_ending with dct_count zero and no same-cycle accept keeps FILL and sets test_has_ended next cycle.
REQ-024 test_ending received in HOLD is latched as pending and applied on return to FILL.
REQ-025 dct_valid is high exactly in HOLD; dct_buffer and dct_count are stable while dct_valid is high and dct_ready is low.
REQ-026 HOLD -> FILL on the dct_valid && dct_ready edge: dct_count clears to 0, dct_buffer clears to 0; test_has_ended sets if that buffer was a flush.
REQ-027 Unfilled slots of a partial (flushed) buffer read as zero.
REQ-028 Latency: the first fragment accepted into an empty buffer appears on dct_buffer one cycle after acceptance; dct_valid rises the cycle after the filling/flushing edge.

Reset
REQ-029 reset_n low asynchronously forces FILL, dct_buffer=0, dct_count=0, dct_valid=0, test_has_ended=0, flush-pending=0, arbiter preference A; a_ready/b_ready are 0 while reset_n is low.
REQ-030 Reset asserted mid-buffer or in HOLD discards the buffer contents without emitting them.

Configuration
REQ-031 With macro CONTROLLER_OCI_DCT_FIXED_PRIO_EN defined, arbitration is fixed priority (A always wins when both valid) and the round-robin pointer is not built; without it, REQ-019 applies.

Structure
REQ-032 Package controller_oci_dct_pkg holds the FSM state typedef (FILL, HOLD) and the default FRAG_W/NFRAG constants.
REQ-033 Arbitration is a sub-module controller_nios2_qsys_0_oci_dct_rr_arb (two requests, accept strobe, two one-hot grants).

Verification
REQ-034 Fragments A=0x01..0x05 only, dct_ready=1 -> dct_valid one cycle, dct_buffer=0x05_04_03_02_01 packed (30'h05103081 equivalent by slot), dct_count=5.
REQ-035 A and B valid continuously -> grants alternate A,B,A,B,A; second buffer starts with B.
REQ-036 dct_ready=0 for 10 cycles in HOLD -> dct_buffer/dct_count stable, a_ready=b_ready=0 throughout, no fragment lost.
REQ-037 Two fragments accepted then test_ending -> dct_count=2, upper slots zero; after drain test_has_ended=1.
REQ-038 test_ending on the same cycle as the fifth fragment -> single HOLD with dct_count=5; test_ending in HOLD -> applied after drain.
REQ-039 reset_n pulsed low in HOLD with dct_count=3 -> all outputs zero immediately, no dct_valid afterward until new fragments arrive.
